// File: rtl/cpu_types_pkg.sv
// Shared CPU types: machine word, fetch FSM states, PC increment.
package cpu_types_pkg;

  typedef logic [31:0] word_t;

  typedef enum logic [1:0] {
    FETCH,
    HOLD,
    HALTED
  } fetch_state_t;

  localparam word_t PC_STEP = 32'd4;

endpackage

// File: rtl/fetch_unit_pc_reg.sv
// Program counter register: synchronous reset to INIT, load on ld_i.
module pc_reg #(
  parameter int              W    = 32,
  parameter logic [W-1:0]    INIT = '0
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         ld_i,
  input  logic [W-1:0] d_i,
  output logic [W-1:0] q_o
);

  logic [W-1:0] pc_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      pc_q <= INIT;
    end else if (ld_i) begin
      pc_q <= d_i;
    end
  end

  assign q_o = pc_q;

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: PC, imem request, IF/ID write/flush control.
module fetch_unit
  import cpu_types_pkg::*;
#(
  parameter logic [31:0] PC_INIT = 32'h00000000,
  parameter int          WORD_W  = 32
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              ihit,
  input  logic [WORD_W-1:0] imemload,
  output logic              imemREN,
  output logic [WORD_W-1:0] imemaddr,
  input  logic              stall,
  input  logic              redirect_valid,
  input  logic [WORD_W-1:0] redirect_addr,
  input  logic              halt_req,
  output logic [WORD_W-1:0] ifinstr,
  output logic [WORD_W-1:0] ifJALjump_addr,
  output logic              ifW,
  output logic              ifRST,
  output logic              halted
);

  fetch_state_t      state_q, state_d;
  logic [WORD_W-1:0] hold_instr_q, hold_instr_d;
  logic [WORD_W-1:0] pc, pc_inc, pc_d;
  logic              pc_ld;

  pc_reg #(
    .W    (WORD_W),
    .INIT (WORD_W'(PC_INIT))
  ) u_pc (
    .clk_i (CLK),
    .rst_i (RST),
    .ld_i  (pc_ld),
    .d_i   (pc_d),
    .q_o   (pc)
  );

  assign pc_inc         = pc + WORD_W'(PC_STEP);
  assign imemaddr       = pc;
  assign ifJALjump_addr = pc_inc;

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q      <= FETCH;
      hold_instr_q <= '0;
    end else begin
      state_q      <= state_d;
      hold_instr_q <= hold_instr_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    hold_instr_d = hold_instr_q;
    pc_d         = pc_inc;
    pc_ld        = 1'b0;
    imemREN      = 1'b0;
    ifinstr      = '0;
    ifW          = 1'b0;
    ifRST        = 1'b0;
    halted       = 1'b0;
    if (RST) begin
      ifRST = 1'b1;
    end else begin
      unique case (state_q)
        FETCH, HOLD: begin
          imemREN = (state_q == FETCH);
          ifinstr = (state_q == FETCH) ? imemload : hold_instr_q;
          if (halt_req) begin
            imemREN = 1'b0;
            ifRST   = 1'b1;
            state_d = HALTED;
          end else if (redirect_valid) begin
            // word-align the target; drop any held/in-flight instr
            ifRST   = 1'b1;
            pc_ld   = 1'b1;
            pc_d    = redirect_addr & ~WORD_W'(3);
            state_d = FETCH;
          end else if (state_q == HOLD) begin
            if (!stall) begin
              ifW     = 1'b1;
              pc_ld   = 1'b1;
              state_d = FETCH;
            end
          end else if (ihit) begin
            if (!stall) begin
              ifW   = 1'b1;
              pc_ld = 1'b1;
            end else begin
              hold_instr_d = imemload;
              state_d      = HOLD;
            end
          end
        end
        HALTED: begin
          halted = 1'b1;
        end
        default: begin
          state_d = FETCH;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit: directed vectors, negedge monitor.
module tb_fetch_unit;
  import cpu_types_pkg::*;

  typedef struct {
    int    id;
    logic  wrap;
    logic  ren;
    logic  ca;
    word_t addr;
    word_t jal;
    logic  ci;
    word_t instr;
    logic  w;
    logic  rs;
    logic  hl;
  } exp_t;

  logic  CLK = 1'b1;
  logic  RST, ihit, stall, redirect_valid, halt_req;
  word_t imemload, redirect_addr;

  logic  a_ren, a_w, a_rs, a_hl;
  word_t a_addr, a_instr, a_jal;
  logic  b_ren, b_w, b_rs, b_hl;
  word_t b_addr, b_instr, b_jal;

  exp_t  sb[$];
  int    n_vec = 0;
  int    n_bad = 0;
  int    vid   = 0;

  always #5 CLK = ~CLK;

  fetch_unit #(.PC_INIT(32'h0)) u_dut (
    .CLK(CLK), .RST(RST), .ihit(ihit), .imemload(imemload),
    .imemREN(a_ren), .imemaddr(a_addr), .stall(stall),
    .redirect_valid(redirect_valid), .redirect_addr(redirect_addr),
    .halt_req(halt_req), .ifinstr(a_instr), .ifJALjump_addr(a_jal),
    .ifW(a_w), .ifRST(a_rs), .halted(a_hl)
  );

  fetch_unit #(.PC_INIT(32'hFFFFFFFC)) u_wrap (
    .CLK(CLK), .RST(RST), .ihit(ihit), .imemload(imemload),
    .imemREN(b_ren), .imemaddr(b_addr), .stall(stall),
    .redirect_valid(redirect_valid), .redirect_addr(redirect_addr),
    .halt_req(halt_req), .ifinstr(b_instr), .ifJALjump_addr(b_jal),
    .ifW(b_w), .ifRST(b_rs), .halted(b_hl)
  );

  task automatic chk(input int id, input string nm,
                     input word_t act, input word_t req);
    if (act !== req) begin
      n_bad++;
      $display("FAIL vec%0d %s: got %h want %h", id, nm, act, req);
    end
  endtask

  always @(negedge CLK) begin
    if (sb.size() > 0) begin
      exp_t  e;
      logic  ren, w, rs, hl;
      word_t ad, ins, jl;
      e = sb.pop_front();
      n_vec++;
      ren = e.wrap ? b_ren : a_ren;
      w   = e.wrap ? b_w   : a_w;
      rs  = e.wrap ? b_rs  : a_rs;
      hl  = e.wrap ? b_hl  : a_hl;
      ad  = e.wrap ? b_addr  : a_addr;
      ins = e.wrap ? b_instr : a_instr;
      jl  = e.wrap ? b_jal   : a_jal;
      chk(e.id, "imemREN", word_t'(ren), word_t'(e.ren));
      chk(e.id, "ifW", word_t'(w), word_t'(e.w));
      chk(e.id, "ifRST", word_t'(rs), word_t'(e.rs));
      chk(e.id, "halted", word_t'(hl), word_t'(e.hl));
      if (e.ca) begin
        chk(e.id, "imemaddr", ad, e.addr);
        chk(e.id, "ifJALjump_addr", jl, e.jal);
      end
      if (e.ci) chk(e.id, "ifinstr", ins, e.instr);
    end
  end

  task automatic step(
    input logic r, input logic ih, input word_t ld, input logic st,
    input logic rv, input word_t ra, input logic hr,
    input logic wr, input logic ren, input logic ca,
    input word_t ad, input word_t jl, input logic ci, input word_t ins,
    input logic w, input logic rs, input logic hl
  );
    exp_t e;
    RST = r; ihit = ih; imemload = ld; stall = st;
    redirect_valid = rv; redirect_addr = ra; halt_req = hr;
    e.id = vid; e.wrap = wr; e.ren = ren; e.ca = ca;
    e.addr = ad; e.jal = jl; e.ci = ci; e.instr = ins;
    e.w = w; e.rs = rs; e.hl = hl;
    sb.push_back(e);
    vid++;
    @(posedge CLK);
    #1;
  endtask

  localparam word_t L  = 32'h20010005;
  localparam word_t LW = 32'h8C220000;
  localparam word_t SW = 32'hAC430004;
  localparam word_t H1 = 32'h11111111;
  localparam word_t N2 = 32'h22222222;

  initial begin
    //   r ih ld  st rv ra hr | wr ren ca addr jal ci instr w rs hl
    step(1,0,0, 0,0,0,0, 0,0,0,0,0, 0,0, 0,1,0);
    step(1,0,0, 0,0,0,0, 0,0,1,32'h0,32'h4, 0,0, 0,1,0);
    step(0,1,L, 0,0,0,0, 0,1,1,32'h0,32'h4, 1,L, 1,0,0);
    step(0,1,L, 0,0,0,0, 0,1,1,32'h4,32'h8, 1,L, 1,0,0);
    step(0,1,L, 0,0,0,0, 0,1,1,32'h8,32'hC, 1,L, 1,0,0);
    step(0,1,L, 0,0,0,0, 0,1,1,32'hC,32'h10, 1,L, 1,0,0);
    for (int i = 0; i < 3; i++)
      step(0,0,L, 0,0,0,0, 0,1,1,32'h10,32'h14, 0,0, 0,0,0);
    step(0,1,LW, 0,0,0,0, 0,1,1,32'h10,32'h14, 1,LW, 1,0,0);
    step(0,1,L, 0,0,0,0, 0,1,1,32'h14,32'h18, 1,L, 1,0,0);
    step(0,1,L, 0,0,0,0, 0,1,1,32'h18,32'h1C, 1,L, 1,0,0);
    step(0,1,L, 0,0,0,0, 0,1,1,32'h1C,32'h20, 1,L, 1,0,0);
    step(0,1,SW, 1,0,0,0, 0,1,1,32'h20,32'h24, 1,SW, 0,0,0);
    step(0,1,0, 1,0,0,0, 0,0,1,32'h20,32'h24, 1,SW, 0,0,0);
    step(0,1,0, 1,0,0,0, 0,0,1,32'h20,32'h24, 1,SW, 0,0,0);
    step(0,1,0, 0,0,0,0, 0,0,1,32'h20,32'h24, 1,SW, 1,0,0);
    step(0,1,H1, 1,0,0,0, 0,1,1,32'h24,32'h28, 1,H1, 0,0,0);
    step(0,1,0, 1,1,32'h103,0, 0,0,1,32'h24,32'h28, 0,0, 0,1,0);
    step(0,1,N2, 0,0,0,0, 0,1,1,32'h100,32'h104, 1,N2, 1,0,0);
    step(0,1,L, 0,1,32'h40,1, 0,0,1,32'h104,32'h108, 0,0, 0,1,0);
    step(0,1,L, 0,1,32'h40,0, 0,0,1,32'h104,32'h108, 1,0, 0,0,1);
    step(0,1,L, 1,0,0,0, 0,0,1,32'h104,32'h108, 1,0, 0,0,1);
    step(1,1,L, 0,0,0,0, 0,0,1,32'h104,32'h108, 0,0, 0,1,0);
    step(0,1,L, 0,0,0,0, 0,1,1,32'h0,32'h4, 1,L, 1,0,0);
    step(1,1,L, 0,0,0,0, 1,0,0,0,0, 0,0, 0,1,0);
    step(0,1,L, 0,0,0,0, 1,1,1,32'hFFFFFFFC,32'h0, 1,L, 1,0,0);
    step(0,1,L, 0,0,0,0, 1,1,1,32'h0,32'h4, 1,L, 1,0,0);
    RST = 1'b1;
    repeat (2) @(negedge CLK);
    if (sb.size() != 0) begin
      n_bad++;
      $display("FAIL drain: %0d left, want 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
